bram_sp_ctrl: RTL and testbench
===============================

Name: bram_sp_ctrl

Overview:
Front-end controller that sits directly upstream of the single-ported BRAM and drives its en/rw/addr/data_in pins. It arbitrates a valid/ready request stream of reads and writes, hides the BRAM's 1-cycle read latency behind a 2-entry response buffer with backpressure, and runs a full-memory clear sweep (framebuffer/depth-buffer clear) on command.

Parameters:
WIDTH, 36, data word width; must match the attached BRAM.
DEPTH, 1024, number of words; address width AW = $clog2(DEPTH).
CLEAR_VALUE, '0, WIDTH-bit word written to every address during a clear.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
clear_start  in  1  one-cycle pulse that starts a clear sweep
clear_busy  out  1  high while the sweep runs
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_rw  in  1  1 = write, 0 = read
req_addr  in  AW  request address
req_data  in  WIDTH  write data
rsp_valid  out  1  read response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  WIDTH  read data
bram_en  out  1  to BRAM en
bram_rw  out  1  to BRAM rw
bram_addr  out  AW  to BRAM addr
bram_din  out  WIDTH  to BRAM data_in
bram_dout  in  WIDTH  from BRAM data_out

Behaviour:
- States: IDLE, CLEAR. Reset sets state IDLE, response FIFO empty, inflight = 0, clear counter = 0. While rst is high: clear_busy = 0, rsp_valid = 0, req_ready = 0, bram_en = 0.
- bram_* outputs are combinational from the current accept/sweep decision; the BRAM registers them.
- IDLE, write: req_ready = 1 for writes. On fire: bram_en = 1, bram_rw = 1, bram_addr = req_addr, bram_din = req_data. No response is generated.
- IDLE, read: accepted iff (fifo_count + inflight - pop) < 2, where pop = rsp_valid && rsp_ready in the same cycle. On fire in cycle N: bram_en = 1, bram_rw = 0. inflight = 1 in N+1. bram_dout is pushed into the FIFO at the end of N+1. rsp_valid is high from N+2.
- Back-to-back reads with rsp_ready held at 1 sustain 1 read per cycle.
- Responses are returned in request order. rsp_data holds stable while rsp_valid && !rsp_ready.
- When no request fires: bram_en = 0 and all other bram_* outputs = 0.
- clear_start in IDLE moves to CLEAR next cycle. clear_start has priority over a same-cycle req_valid: that request is not accepted. clear_start during CLEAR is ignored.
- CLEAR: req_ready = 0 and clear_busy = 1. Each cycle: bram_en = 1, bram_rw = 1, bram_addr = counter, bram_din = CLEAR_VALUE. The counter runs 0..DEPTH-1. After the write to DEPTH-1 the state returns to IDLE, so clear_busy is high for exactly DEPTH cycles.
- A read issued in the cycle before clear_start still completes: it is captured into the FIFO and returned.
- The FIFO keeps draining to rsp_* during CLEAR.
- Reset mid-clear aborts the sweep; the memory is left partially cleared.
- The counter is AW+1 bits wide to detect the end with a non-power-of-2 DEPTH; no address wrap is permitted.

Optional Feature:
BRAM_SP_CTRL_STATS_EN: when defined, adds two 32-bit output ports:
- stat_rd_cnt: accepted reads.
- stat_wr_cnt: accepted request writes; clear writes are excluded.
Both reset to 0, increment by 1 per accept, and wrap at 2^32.
When the macro is undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then write addr 5 = 0xA5A5, then read addr 5 in cycle N with rsp_ready = 1 -> rsp_valid in N+2 only, rsp_data = 0xA5A5; bram_en low in idle cycles.
- Write addrs 0..7 = i*3, then 8 back-to-back reads with rsp_ready = 1 -> 8 consecutive rsp_valid cycles, data 0,3,...,21 in order.
- rsp_ready = 0 and 4 reads presented -> exactly 2 accepted and req_ready then low. Release rsp_ready -> first 2 responses return in order, then the remaining 2 are accepted and returned.
- DEPTH = 16, CLEAR_VALUE = 0x7: fill memory, pulse clear_start with req_valid high -> request not accepted; clear_busy high 16 cycles; bram writes to addrs 0..15; later reads all return 0x7.
- Issue a read in cycle N and clear_start in N+1 -> the read response is still delivered. Assert rst at sweep step 8 -> clear_busy = 0 next cycle, addrs 8..15 keep their old data.
- Stats build: 3 writes and 5 reads -> stat_wr_cnt = 3, stat_rd_cnt = 5; a clear leaves both unchanged.

Source files
------------

// File: rtl/bram_sp_ctrl.sv
// Single-port BRAM front end: valid/ready request arbitration, 2-deep read response buffer, full-memory clear sweep.
// Optional BRAM_SP_CTRL_STATS_EN adds accepted-read / accepted-write counters.
//
// state | meaning
// IDLE  | accepting requests; clear_start moves to CLEAR
// CLEAR | writing CLEAR_VALUE to every address, requests blocked
module bram_sp_ctrl #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 1024,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_start,
    output logic             clear_busy,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             bram_en,
    output logic             bram_rw,
    output logic [AW-1:0]    bram_addr,
    output logic [WIDTH-1:0] bram_din,
    input  logic [WIDTH-1:0] bram_dout
`ifdef BRAM_SP_CTRL_STATS_EN
    ,
    output logic [31:0]      stat_rd_cnt,
    output logic [31:0]      stat_wr_cnt
`endif
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

    state_t           state, state_nx;
    logic [AW:0]      clr_cnt, clr_cnt_nx;
    logic [WIDTH-1:0] fifo_mem [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       fifo_cnt;
    logic             inflight;
    logic             pop, push, rd_ok, rd_fire;
    logic [2:0]       occ;

    assign rsp_valid = !rst && (fifo_cnt != 2'd0);
    assign rsp_data  = fifo_mem[rd_ptr];
    assign pop       = rsp_valid && rsp_ready;
    assign push      = inflight;

    // A read in flight already owns a buffer slot; a same-cycle pop frees one.
    assign occ   = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
    assign rd_ok = occ < 3'd2;

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        req_ready  = 1'b0;
        clear_busy = 1'b0;
        bram_en    = 1'b0;
        bram_rw    = 1'b0;
        bram_addr  = '0;
        bram_din   = '0;
        rd_fire    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state_nx = CLEAR;
                    end else begin
                        req_ready = req_rw || rd_ok;
                        if (req_valid && req_ready) begin
                            bram_en   = 1'b1;
                            bram_rw   = req_rw;
                            bram_addr = req_addr;
                            bram_din  = req_rw ? req_data : '0;
                            rd_fire   = !req_rw;
                        end
                    end
                end
                CLEAR: begin
                    clear_busy = 1'b1;
                    bram_en    = 1'b1;
                    bram_rw    = 1'b1;
                    bram_addr  = clr_cnt[AW-1:0];
                    bram_din   = CLEAR_VALUE;
                    if (clr_cnt == LAST_ADDR) begin
                        state_nx   = IDLE;
                        clr_cnt_nx = '0;
                    end else begin
                        clr_cnt_nx = clr_cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            fifo_cnt <= 2'd0;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            state    <= state_nx;
            clr_cnt  <= clr_cnt_nx;
            inflight <= rd_fire;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // BRAM data is valid the cycle after a read was issued.
    always_ff @(posedge clk) begin
        if (!rst && push) fifo_mem[wr_ptr] <= bram_dout;
    end

`ifdef BRAM_SP_CTRL_STATS_EN
    logic wr_fire;
    assign wr_fire = bram_en && bram_rw && !clear_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
        end else begin
            if (rd_fire) stat_rd_cnt <= stat_rd_cnt + 32'd1;
            if (wr_fire) stat_wr_cnt <= stat_wr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bram_sp_ctrl.sv
// Bench for bram_sp_ctrl with a small BRAM model; read expectations are queued on accept and checked on response.
module tb_bram_sp_ctrl;
    localparam int WIDTH = 36;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear_start = 1'b0;
    logic             clear_busy;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_rw = 1'b0;
    logic [AW-1:0]    req_addr = '0;
    logic [WIDTH-1:0] req_data = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic             bram_en;
    logic             bram_rw;
    logic [AW-1:0]    bram_addr;
    logic [WIDTH-1:0] bram_din;
    logic [WIDTH-1:0] bram_dout = '0;
`ifdef BRAM_SP_CTRL_STATS_EN
    logic [31:0]      stat_rd_cnt;
    logic [31:0]      stat_wr_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] bram_mem  [DEPTH];
    logic [WIDTH-1:0] model_mem [DEPTH];
    logic [WIDTH-1:0] exp_q [$];

    bram_sp_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLEAR_VALUE(36'h7)) dut (
        .clk(clk), .rst(rst),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .bram_en(bram_en), .bram_rw(bram_rw), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
`ifdef BRAM_SP_CTRL_STATS_EN
        , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_rw) bram_mem[bram_addr] <= bram_din;
            else         bram_dout <= bram_mem[bram_addr];
        end
    end

    // Scoreboard: compare responses first, then record this cycle's accepted request.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected got=%h", rsp_data);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (rsp_data !== e) begin
                        bad++;
                        $display("FAIL rsp_data got=%h exp=%h", rsp_data, e);
                    end
                end
            end
            if (req_valid && req_ready) begin
                if (req_rw) model_mem[req_addr] = req_data;
                else        exp_q.push_back(model_mem[req_addr]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic rw, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bit fired = 1'b0;
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = d;
        for (int c = 0; c < 40 && !fired; c++) begin
            @(negedge clk);
            fired = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        total++;
        if (!fired) begin
            bad++;
            $display("FAIL send_accept rw=%0b addr=%0d got=not_accepted exp=accepted", rw, a);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain pending=%0d exp=0", name, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_rw = 1'b0; clear_start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({clear_busy, rsp_valid, req_ready, bram_en} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got busy/rv/rr/en=%b exp=0000",
                     {clear_busy, rsp_valid, req_ready, bram_en});
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; clear_start = 1'b0;
        @(negedge clk);
        total++;
        if ({clear_busy, rsp_valid, req_ready, bram_en} !== 4'b0010) begin
            bad++;
            $display("FAIL post_reset_idle got busy/rv/rr/en=%b exp=0010",
                     {clear_busy, rsp_valid, req_ready, bram_en});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_rw();
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 4'd5; req_data = 36'hA5A5;
        @(negedge clk);
        total++;
        if (!(req_ready === 1'b1 && bram_en === 1'b1 && bram_rw === 1'b1 &&
              bram_addr === 4'd5 && bram_din === 36'hA5A5)) begin
            bad++;
            $display("FAIL write_pins got rr=%b en=%b rw=%b addr=%0d din=%h exp 1 1 1 5 a5a5",
                     req_ready, bram_en, bram_rw, bram_addr, bram_din);
        end
        @(posedge clk); #1;
        req_rw = 1'b0;
        @(negedge clk);
        total++;
        if (!(req_ready === 1'b1 && bram_en === 1'b1 && bram_rw === 1'b0 &&
              bram_addr === 4'd5 && rsp_valid === 1'b0)) begin
            bad++;
            $display("FAIL read_pins got rr=%b en=%b rw=%b addr=%0d rv=%b exp 1 1 0 5 0",
                     req_ready, bram_en, bram_rw, bram_addr, rsp_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || bram_en !== 1'b0) begin
            bad++;
            $display("FAIL read_n1 got rv=%b en=%b exp rv=0 en=0", rsp_valid, bram_en);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 36'hA5A5) begin
            bad++;
            $display("FAIL read_n2 got rv=%b data=%h exp rv=1 data=a5a5", rsp_valid, rsp_data);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_n3 got rv=%b exp 0", rsp_valid);
        end
        @(posedge clk); #1;
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) send(1'b1, 4'(i), 36'(i * 3));
        req_valid = 1'b1; req_rw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_addr = 4'(i);
            @(negedge clk);
            total++;
            if (req_ready !== 1'b1 || rsp_valid !== (i >= 2)) begin
                bad++;
                $display("FAIL b2b_cycle%0d got rr=%b rv=%b exp rr=1 rv=%0b", i, req_ready, rsp_valid, i >= 2);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== (i < 2)) begin
                bad++;
                $display("FAIL b2b_tail%0d got rv=%b exp %0b", i, rsp_valid, i < 2);
            end
        end
        @(posedge clk); #1;
        wait_drain("b2b");
    endtask

    task automatic test_backpressure();
        int  idx = 0;
        bit  f;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'd1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            f = req_ready;
            @(posedge clk); #1;
            if (f) begin idx++; req_addr = 4'(idx + 1); end
        end
        @(negedge clk);
        total++;
        if (idx != 2 || req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== model_mem[1]) begin
            bad++;
            $display("FAIL bp_stall got acc=%0d rr=%b rv=%b data=%h exp acc=2 rr=0 rv=1 data=%h",
                     idx, req_ready, rsp_valid, rsp_data, model_mem[1]);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clk);
            f = req_ready;
            @(posedge clk); #1;
            if (f) begin
                idx++;
                if (idx == 4) req_valid = 1'b0;
                else req_addr = 4'(idx + 1);
            end
        end
        req_valid = 1'b0;
        total++;
        if (idx != 4) begin
            bad++;
            $display("FAIL bp_release got acc=%0d exp 4", idx);
        end
        wait_drain("bp");
    endtask

    task automatic test_clear();
        for (int i = 0; i < DEPTH; i++) send(1'b1, 4'(i), 36'(100 + i));
        clear_start = 1'b1; req_valid = 1'b1; req_rw = 1'b1; req_addr = 4'd3; req_data = 36'd999;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0 || bram_en !== 1'b0 || clear_busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_priority got rr=%b en=%b busy=%b exp 0 0 0", req_ready, bram_en, clear_busy);
        end
        @(posedge clk); #1;
        clear_start = 1'b0; req_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            total++;
            if (!(clear_busy === 1'b1 && bram_en === 1'b1 && bram_rw === 1'b1 &&
                  bram_addr === 4'(k) && bram_din === 36'h7 && req_ready === 1'b0)) begin
                bad++;
                $display("FAIL clear_step%0d got busy=%b en=%b rw=%b addr=%0d din=%h rr=%b exp 1 1 1 %0d 7 0",
                         k, clear_busy, bram_en, bram_rw, bram_addr, bram_din, req_ready, k);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (clear_busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_end got busy=%b exp 0", clear_busy);
        end
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 36'h7;
        for (int i = 0; i < DEPTH; i++) send(1'b0, 4'(i), '0);
        wait_drain("clear");
    endtask

    task automatic test_clear_abort();
        for (int i = 0; i < DEPTH; i++) send(1'b1, 4'(i), 36'(200 + i));
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'd9;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_read_accept got rr=%b exp 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (clear_busy !== 1'b1 || bram_addr !== 4'(k)) begin
                bad++;
                $display("FAIL abort_step%0d got busy=%b addr=%0d exp 1 %0d", k, clear_busy, bram_addr, k);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (clear_busy !== 1'b0 || bram_en !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL abort_rst got busy=%b en=%b pending=%0d exp 0 0 0", clear_busy, bram_en, exp_q.size());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (clear_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_after got busy=%b exp 0", clear_busy);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) model_mem[i] = 36'h7;
        for (int i = 0; i < DEPTH; i++) send(1'b0, 4'(i), '0);
        wait_drain("abort");
    endtask

`ifdef BRAM_SP_CTRL_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (stat_rd_cnt !== 32'd0 || stat_wr_cnt !== 32'd0) begin
            bad++;
            $display("FAIL stats_reset got rd=%0d wr=%0d exp 0 0", stat_rd_cnt, stat_wr_cnt);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send(1'b1, 4'(i), 36'(50 + i));
        for (int i = 0; i < 5; i++) send(1'b0, 4'(i), '0);
        wait_drain("stats");
        total++;
        if (stat_rd_cnt !== 32'd5 || stat_wr_cnt !== 32'd3) begin
            bad++;
            $display("FAIL stats_count got rd=%0d wr=%0d exp 5 3", stat_rd_cnt, stat_wr_cnt);
        end
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        total++;
        if (stat_rd_cnt !== 32'd5 || stat_wr_cnt !== 32'd3 || clear_busy !== 1'b0) begin
            bad++;
            $display("FAIL stats_clear got rd=%0d wr=%0d busy=%b exp 5 3 0", stat_rd_cnt, stat_wr_cnt, clear_busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_rw();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_clear_abort();
`ifdef BRAM_SP_CTRL_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
